// File: rtl/pl1r_pkg.sv
// PL1R shared definitions: decoder states and the
// framing constants shared with the preamble catcher.
package pl1r_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    PARITY,
    DONE
  } pl1r_state_e;

  localparam int PL1R_MIN_HIGH   = 7;
  localparam int PL1R_DATA_W     = 8;
  localparam int PL1R_BIT_CYCLES = 4;

endpackage

// File: rtl/pl1r_bit_timer.sv
// PL1R bit-window timer: cycle and bit counters that
// mark the sample point and the end of the last data bit.
module pl1r_bit_timer #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int SAMPLE_OFS = BIT_CYCLES / 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_sample_pt,
  output logic o_last_bit
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_SMP  = CW'(SAMPLE_OFS);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic [CW-1:0] r_cyc_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cyc_cnt == CYC_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || !i_run) begin
      r_cyc_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_wrap) begin
      r_cyc_cnt <= '0;
      if (r_bit_cnt != BIT_MAX)
        r_bit_cnt <= r_bit_cnt + BW'(1);
    end else begin
      r_cyc_cnt <= r_cyc_cnt + CW'(1);
    end
  end

  assign o_sample_pt = i_run && (r_cyc_cnt == CYC_SMP);
  assign o_last_bit  = i_run && w_wrap &&
                       (r_bit_cnt == BIT_LAST);

endmodule

// File: rtl/pl1r_frame_decoder.sv
// PL1R frame decoder: receives the MSB-first serial word plus
// even parity that follows a preamble and strobes the result.
module pl1r_frame_decoder
  import pl1r_pkg::*;
#(
  parameter int DATA_W     = PL1R_DATA_W,
  parameter int BIT_CYCLES = PL1R_BIT_CYCLES,
  parameter int SAMPLE_OFS = BIT_CYCLES / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DigIn,
  input  logic              PL1R_got,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_valid,
  output logic              parity_err,
  output logic              frame_abort,
  output logic              busy
);

  pl1r_state_e       r_state;
  logic              r_pl1r_q;
  logic              r_rst_q;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;

  logic w_edge;
  logic w_run;
  logic w_sample;
  logic w_last;

  // r_rst_q masks a level that was already high across reset
  assign w_edge = PL1R_got && !r_pl1r_q && !r_rst_q;
  assign w_run  = (r_state == RECV) || (r_state == PARITY);

  pl1r_bit_timer #(
    .DATA_W     (DATA_W),
    .BIT_CYCLES (BIT_CYCLES),
    .SAMPLE_OFS (SAMPLE_OFS)
  ) u_timer (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (w_edge),
    .i_run       (w_run),
    .o_sample_pt (w_sample),
    .o_last_bit  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pl1r_q    <= 1'b0;
      r_rst_q     <= 1'b1;
      r_shift     <= '0;
      r_par       <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_rst_q     <= 1'b0;
      r_pl1r_q    <= PL1R_got;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_abort <= 1'b0;
      if (w_edge) begin
        r_state     <= RECV;
        r_shift     <= '0;
        r_par       <= 1'b0;
        busy        <= 1'b1;
        frame_abort <= w_run;
      end else begin
        unique case (r_state)
          IDLE: begin
            busy <= 1'b0;
          end
          RECV: begin
            if (w_sample) begin
              r_shift <= {r_shift[DATA_W-2:0], DigIn};
              r_par   <= r_par ^ DigIn;
            end
            if (w_last)
              r_state <= PARITY;
          end
          PARITY: begin
            if (w_sample) begin
              r_state <= DONE;
              busy    <= 1'b0;
              r_par   <= r_par ^ DigIn;
              if (r_par ^ DigIn) begin
                parity_err <= 1'b1;
              end else begin
                frame_valid <= 1'b1;
                frame_data  <= r_shift;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pl1r_frame_decoder.sv
// Bench for pl1r_frame_decoder: frame table, corner sequences
// and random traffic against a timing-formula reference model.
module tb_pl1r_frame_decoder;

  localparam int DW = 8;
  localparam int BC = 4;
  localparam int SO = 2;
  localparam int PAR_OFS = 1 + DW * BC + SO;
  localparam int BODY = DW * BC + BC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          DigIn = 1'b0;
  logic          PL1R_got = 1'b0;
  logic [DW-1:0] frame_data;
  logic          frame_valid;
  logic          parity_err;
  logic          frame_abort;
  logic          busy;

  always #5 clk = ~clk;

  pl1r_frame_decoder #(
    .DATA_W     (DW),
    .BIT_CYCLES (BC),
    .SAMPLE_OFS (SO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .DigIn       (DigIn),
    .PL1R_got    (PL1R_got),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .parity_err  (parity_err),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;

  logic hist [0:8191];
  logic m_act = 1'b0;
  int   m_E = 0;
  logic [DW-1:0] m_fd = '0;
  logic m_pgot = 1'b0;
  logic m_prst = 1'b1;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, a, e);
    end
  endtask

  // one clock: apply inputs, predict, clock, compare
  task automatic step(input logic g, input logic d, input logic r);
    logic          edg;
    logic [DW-1:0] w;
    logic          ev, ep, ea, eb;
    PL1R_got = g;
    DigIn    = d;
    rst      = r;
    hist[t]  = d;
    ev = 1'b0;
    ep = 1'b0;
    ea = 1'b0;
    if (r) begin
      m_act = 1'b0;
      m_fd  = '0;
    end else begin
      edg = g && !m_pgot && !m_prst;
      if (m_act && !edg && t == m_E + PAR_OFS) begin
        w = '0;
        for (int k = 0; k < DW; k++)
          w = (w << 1) | DW'(hist[m_E + 1 + k * BC + SO]);
        if (((^w) ^ d) == 1'b0) begin
          ev   = 1'b1;
          m_fd = w;
        end else begin
          ep = 1'b1;
        end
        m_act = 1'b0;
      end
      if (edg) begin
        ea    = m_act;
        m_E   = t;
        m_act = 1'b1;
      end
    end
    eb = m_act && (t <= m_E + PAR_OFS - 1);
    m_pgot = g;
    m_prst = r;
    @(posedge clk);
    #1;
    chk("step", 32'({frame_data, frame_valid, parity_err,
                     frame_abort, busy}),
        32'({m_fd, ev, ep, ea, eb}));
    t++;
  endtask

  task automatic frame_body(input logic [DW-1:0] w, input logic pb,
                            input logic g, input logic g_last,
                            output logic v, output logic pe,
                            output logic [DW-1:0] d,
                            output int nb, output int na);
    int   k;
    logic b;
    logic rb;
    nb = 0;
    na = 0;
    v  = 1'b0;
    pe = 1'b0;
    d  = '0;
    for (int i = 0; i < BODY; i++) begin
      k  = i / BC;
      b  = (k < DW) ? w[DW-1-k] : pb;
      rb = 1'($urandom_range(0, 1));
      step((i == BODY - 1) ? g_last : g,
           (i % BC == SO) ? b : rb, 1'b0);
      nb += int'(busy);
      na += int'(frame_abort);
      if (i == DW * BC + SO) begin
        v  = frame_valid;
        pe = parity_err;
        d  = frame_data;
      end
    end
  endtask

  typedef struct {
    logic [DW-1:0] word;
    logic          pbit;
    logic          ev;
    logic          ep;
    logic [DW-1:0] ed;
  } fvec_t;

  fvec_t tbl [6];

  initial begin
    logic          v, pe, g;
    logic [DW-1:0] d;
    int            nb, na;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF};
    tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    chk("reset_state", 32'({frame_data, frame_valid, parity_err,
                            frame_abort, busy}), 32'h0);
    step(1'b0, 1'b0, 1'b0);

    // PL1R_got held high through each frame (level hold)
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      frame_body(tbl[i].word, tbl[i].pbit, 1'b1, 1'b1,
                 v, pe, d, nb, na);
      chk("tbl_valid", 32'(v), 32'(tbl[i].ev));
      chk("tbl_perr", 32'(pe), 32'(tbl[i].ep));
      chk("tbl_data", 32'(d), 32'(tbl[i].ed));
      chk("tbl_busy_len", nb, 34);
      chk("tbl_abort", na, 0);
    end

    // second preamble 15 cycles into a frame
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 15; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("abort_strobe", 32'({frame_abort, frame_valid, parity_err}),
        32'b100);
    frame_body(8'h3C, 1'b0, 1'b1, 1'b0, v, pe, d, nb, na);
    chk("abort_then_valid", 32'({v, pe}), 32'b10);
    chk("abort_then_data", 32'(d), 32'h3C);

    // reset 20 cycles into a frame
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_state", 32'({frame_data, frame_valid, parity_err,
                             frame_abort, busy}), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    frame_body(8'h5A, 1'b0, 1'b1, 1'b1, v, pe, d, nb, na);
    chk("post_rst_data", 32'({v, d}), 32'h15A);

    // new preamble in the DONE cycle
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    frame_body(8'h81, 1'b0, 1'b0, 1'b1, v, pe, d, nb, na);
    chk("b2b_first", 32'({v, d}), 32'h181);
    chk("b2b_first_abort", na, 0);
    chk("b2b_edge_busy", 32'({busy, frame_abort}), 32'b10);
    frame_body(8'h7E, 1'b0, 1'b1, 1'b0, v, pe, d, nb, na);
    chk("b2b_second", 32'({v, d}), 32'h17E);
    chk("b2b_second_abort", na, 0);

    // level already high when reset releases is not an edge
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("rst_level_no_edge", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 1'b0);

    // random traffic against the model
    g = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) g = ~g;
      step(g, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 399) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
